// File: rtl/tge_mon_pkg.sv
// Shared constants for the 10GbE link/activity monitor.
// Counter indices, XAUI lane-status field location and a lane check helper.
package tge_mon_pkg;

    typedef enum logic [1:0] {
        CNT_RX_GOOD   = 2'd0,
        CNT_RX_BAD    = 2'd1,
        CNT_TX        = 2'd2,
        CNT_LINK_DOWN = 2'd3
    } cnt_idx_e;

    localparam int NUM_CNT = 4;

    localparam logic [4:0] PHY_LANES_UP = 5'b11111;
    localparam int PHY_LANE_LO = 2;
    localparam int PHY_LANE_HI = 6;

    function automatic logic lanes_ok(input logic [4:0] lanes);
        return lanes == PHY_LANES_UP;
    endfunction

endpackage

// File: rtl/tge_act_stretch.sv
// Activity stretcher: a trigger loads all-ones, then counts down while MSB is set.
// Ports: clk, rst (sync, active-high), trig (strobe), out (stretched MSB).
module tge_act_stretch #(
    parameter int LED_WIDTH = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic out
);

    logic [LED_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= '1;
        end else if (cnt[LED_WIDTH-1]) begin
            cnt <= cnt - LED_WIDTH'(1);
        end
    end

    assign out = cnt[LED_WIDTH-1];

endmodule

// File: rtl/tge_link_monitor.sv
// Multi-channel 10GbE link monitor: debounced link-up, LED stretchers, event counters.
// Ports: clk, rst, phy_status, rx_good_frame, rx_bad_frame, tx_start, stat_rd,
//        stat_addr, stat_clr_all -> stat_data, stat_valid, link_up, link_change, led_*.
module tge_link_monitor
    import tge_mon_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int LED_WIDTH     = 26,
    parameter int CNT_WIDTH     = 32,
    parameter int UP_HOLDOFF    = 1024,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [32*NUM_CHANNELS-1:0]    phy_status,
    input  logic [NUM_CHANNELS-1:0]       rx_good_frame,
    input  logic [NUM_CHANNELS-1:0]       rx_bad_frame,
    input  logic [NUM_CHANNELS-1:0]       tx_start,
    input  logic                          stat_rd,
    input  logic [$clog2(NUM_CHANNELS)+1:0] stat_addr,
    input  logic                          stat_clr_all,
    output logic [CNT_WIDTH-1:0]          stat_data,
    output logic                          stat_valid,
    output logic [NUM_CHANNELS-1:0]       link_up,
    output logic [NUM_CHANNELS-1:0]       link_change,
    output logic [NUM_CHANNELS-1:0]       led_up,
    output logic [NUM_CHANNELS-1:0]       led_rx,
    output logic [NUM_CHANNELS-1:0]       led_tx
);

    localparam int AW = $clog2(NUM_CHANNELS) + 2;
    localparam int HW = (UP_HOLDOFF > 0) ? $clog2(UP_HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(UP_HOLDOFF);
    localparam int NCNT = NUM_CHANNELS * NUM_CNT;

    logic [NUM_CHANNELS-1:0] phy_ok;
    logic [NUM_CHANNELS-1:0] phy_ok_q;
    logic [NUM_CHANNELS-1:0] rx_good_q;
    logic [NUM_CHANNELS-1:0] rx_bad_q;
    logic [NUM_CHANNELS-1:0] tx_q;
    logic [NUM_CHANNELS-1:0] link_up_prev;
    logic [NUM_CHANNELS-1:0] link_fall;
    logic [NUM_CHANNELS-1:0] rx_msb;
    logic [NUM_CHANNELS-1:0] tx_msb;
    logic [NUM_CHANNELS-1:0] dn_msb;
    logic [CNT_WIDTH-1:0]    cnt_all [NCNT];
    logic [CNT_WIDTH-1:0]    rd_val;

    // Only the lane-sync bits of each status word matter here.
    logic unused_phy;
    assign unused_phy = ^phy_status;

    // Trigger stage: every input strobe is registered once before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            phy_ok_q  <= '0;
            rx_good_q <= '0;
            rx_bad_q  <= '0;
            tx_q      <= '0;
        end else begin
            phy_ok_q  <= phy_ok;
            rx_good_q <= rx_good_frame;
            rx_bad_q  <= rx_bad_frame;
            tx_q      <= tx_start;
        end
    end

    // link_fall is seen in the first cycle link_up is low.
    assign link_fall = link_up_prev & ~link_up;

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_ch
        logic [HW-1:0]      hold_cnt;
        logic               link_r;
        logic [NUM_CNT-1:0] evt;

        assign phy_ok[n] = lanes_ok(phy_status[32*n+PHY_LANE_HI -: 5]);

        // Any bad status sample restarts the holdoff; link_up rises
        // in the same cycle the count reaches UP_HOLDOFF.
        always_ff @(posedge clk) begin
            if (rst || !phy_ok_q[n]) begin
                hold_cnt <= '0;
                link_r   <= 1'b0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
                link_r   <= (hold_cnt + HW'(1)) == HOLD_MAX;
            end else begin
                link_r   <= 1'b1;
            end
        end

        assign link_up[n] = link_r;

        tge_act_stretch #(.LED_WIDTH(LED_WIDTH)) u_rx (
            .clk  (clk),
            .rst  (rst),
            .trig (rx_good_q[n]),
            .out  (rx_msb[n])
        );

        tge_act_stretch #(.LED_WIDTH(LED_WIDTH)) u_tx (
            .clk  (clk),
            .rst  (rst),
            .trig (tx_q[n]),
            .out  (tx_msb[n])
        );

        tge_act_stretch #(.LED_WIDTH(LED_WIDTH)) u_dn (
            .clk  (clk),
            .rst  (rst),
            .trig (~phy_ok_q[n]),
            .out  (dn_msb[n])
        );

        assign evt[CNT_RX_GOOD]   = rx_good_q[n];
        assign evt[CNT_RX_BAD]    = rx_bad_q[n];
        assign evt[CNT_TX]        = tx_q[n];
        assign evt[CNT_LINK_DOWN] = link_fall[n];

        for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt;
            logic                 rd_hit;

            assign rd_hit = stat_rd && (stat_addr == AW'(n * NUM_CNT + k));

            // clr_all beats everything; clear-on-read keeps a
            // coincident event so nothing is lost.
            always_ff @(posedge clk) begin
                if (rst || stat_clr_all) begin
                    cnt <= '0;
                end else if (CLEAR_ON_READ != 0 && rd_hit) begin
                    cnt <= evt[k] ? CNT_WIDTH'(1) : '0;
                end else if (evt[k] && cnt != '1) begin
                    cnt <= cnt + CNT_WIDTH'(1);
                end
            end

            assign cnt_all[n*NUM_CNT+k] = cnt;
        end
    end

    // Addresses past the last channel match nothing and read 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (stat_addr == AW'(i)) begin
                rd_val = cnt_all[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_data  <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= stat_rd;
            if (stat_rd) begin
                stat_data <= rd_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_up_prev <= '0;
            link_change  <= '0;
            led_up       <= '0;
            led_rx       <= '0;
            led_tx       <= '0;
        end else begin
            link_up_prev <= link_up;
            link_change  <= link_up ^ link_up_prev;
            led_up       <= link_up & ~dn_msb;
            led_rx       <= rx_msb;
            led_tx       <= tx_msb;
        end
    end

endmodule

// File: tb/tb_tge_link_monitor.sv
// Directed bench for tge_link_monitor: LED timing, debounce, counters, read port.
// Read results go through an expected-value queue popped when stat_valid shows.
module tb_tge_link_monitor;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] phy_status;
    logic [3:0]   rx_good, rx_bad, tx_start;
    logic         stat_rd, stat_clr_all;
    logic [3:0]   stat_addr;
    logic [3:0]   stat_data;
    logic         stat_valid;
    logic [3:0]   link_up, link_change, led_up, led_rx, led_tx;

    logic [95:0]  phy3;
    logic [2:0]   rxg3, rxb3, tx3;
    logic         rd3, clr3;
    logic [3:0]   addr3, data3;
    logic         valid3;
    logic [2:0]   lu3, lc3, lup3, lrx3, ltx3;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    tge_link_monitor #(
        .NUM_CHANNELS(4), .LED_WIDTH(4), .CNT_WIDTH(4),
        .UP_HOLDOFF(8), .CLEAR_ON_READ(1)
    ) dut (
        .clk(clk), .rst(rst), .phy_status(phy_status),
        .rx_good_frame(rx_good), .rx_bad_frame(rx_bad),
        .tx_start(tx_start), .stat_rd(stat_rd),
        .stat_addr(stat_addr), .stat_clr_all(stat_clr_all),
        .stat_data(stat_data), .stat_valid(stat_valid),
        .link_up(link_up), .link_change(link_change),
        .led_up(led_up), .led_rx(led_rx), .led_tx(led_tx)
    );

    tge_link_monitor #(
        .NUM_CHANNELS(3), .LED_WIDTH(4), .CNT_WIDTH(4),
        .UP_HOLDOFF(8), .CLEAR_ON_READ(1)
    ) dut3 (
        .clk(clk), .rst(rst), .phy_status(phy3),
        .rx_good_frame(rxg3), .rx_bad_frame(rxb3),
        .tx_start(tx3), .stat_rd(rd3),
        .stat_addr(addr3), .stat_clr_all(clr3),
        .stat_data(data3), .stat_valid(valid3),
        .link_up(lu3), .link_change(lc3),
        .led_up(lup3), .led_rx(lrx3), .led_tx(ltx3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input logic [3:0] addr, input logic [3:0] exp,
                            input string tag);
        logic [3:0] e;
        stat_addr = addr;
        stat_rd   = 1'b1;
        sb.push_back(exp);
        step();
        stat_rd = 1'b0;
        chk({tag, "_valid"}, 32'(stat_valid), 32'd1);
        e = sb.pop_front();
        chk(tag, 32'(stat_data), 32'(e));
    endtask

    task automatic read3_chk(input logic [3:0] addr, input logic [3:0] exp,
                             input string tag);
        logic [3:0] e;
        addr3 = addr;
        rd3   = 1'b1;
        sb.push_back(exp);
        step();
        rd3 = 1'b0;
        chk({tag, "_valid"}, 32'(valid3), 32'd1);
        e = sb.pop_front();
        chk(tag, 32'(data3), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        phy_status = '0; rx_good = '0; rx_bad = '0; tx_start = '0;
        stat_rd = 1'b0; stat_clr_all = 1'b0; stat_addr = '0;
        phy3 = '0; rxg3 = '0; rxb3 = '0; tx3 = '0;
        rd3 = 1'b0; clr3 = 1'b0; addr3 = '0;
        repeat (3) step();

        chk("rst_led_rx", 32'(led_rx), 32'd0);
        chk("rst_led_tx", 32'(led_tx), 32'd0);
        chk("rst_led_up", 32'(led_up), 32'd0);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_link_chg", 32'(link_change), 32'd0);
        chk("rst_valid", 32'(stat_valid), 32'd0);
        chk("rst_data", 32'(stat_data), 32'd0);

        rst = 1'b0;
        repeat (4) step();

        // rx LED: pulse in cycle 0 -> high cycles 3..10
        rx_good[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) rx_good[0] = 1'b0;
            chk($sformatf("led_rx0_k%0d", k), 32'(led_rx[0]),
                32'(k >= 3 && k <= 10));
            if (k == 5) chk("led_rx_others", 32'(led_rx[3:1]), 32'd0);
        end

        // tx retrigger at 0 and 5 -> continuous 3..15
        tx_start[1] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            tx_start[1] = (k == 5);
            chk($sformatf("led_tx1_k%0d", k), 32'(led_tx[1]),
                32'(k >= 3 && k <= 15));
        end

        // ch2 lanes good at 0, glitch at 4 -> link_up at 14, change at 15
        phy_status[70:66] = 5'b11111;
        for (int k = 1; k <= 18; k++) begin
            step();
            phy_status[70:66] = (k == 4) ? 5'b00000 : 5'b11111;
            chk($sformatf("link_up2_k%0d", k), 32'(link_up[2]),
                32'(k >= 14));
            chk($sformatf("link_chg2_k%0d", k), 32'(link_change[2]),
                32'(k == 15));
        end

        // ch1 up, then drop
        phy_status[38:34] = 5'b11111;
        repeat (20) step();
        chk("link_up1_up", 32'(link_up[1]), 32'd1);
        chk("led_up1_up", 32'(led_up[1]), 32'd1);
        phy_status[38:34] = 5'b00000;
        step();
        chk("link_up1_d1", 32'(link_up[1]), 32'd1);
        step();
        chk("link_up1_d2", 32'(link_up[1]), 32'd0);
        step();
        chk("led_up1_d3", 32'(led_up[1]), 32'd0);
        chk("link_chg1_d3", 32'(link_change[1]), 32'd1);
        step();
        chk("link_chg1_d4", 32'(link_change[1]), 32'd0);
        read_chk(4'h7, 4'd1, "rd_ch1_down");
        read_chk(4'h0, 4'd1, "rd_ch0_good");

        // five frames on ch3, read with a coincident frame
        rx_good[3] = 1'b1;
        repeat (5) step();
        rx_good[3] = 1'b0;
        repeat (2) step();
        rx_good[3] = 1'b1;
        step();
        rx_good[3] = 1'b0;
        read_chk(4'hC, 4'd5, "rd_ch3_good5");
        repeat (2) step();
        read_chk(4'hC, 4'd1, "rd_ch3_cor1");
        repeat (3) step();
        chk("hold_data", 32'(stat_data), 32'd1);
        chk("hold_valid", 32'(stat_valid), 32'd0);
        read_chk(4'hC, 4'd0, "rd_ch3_clr");

        // saturation and clear-all
        rx_bad[0] = 1'b1;
        repeat (20) step();
        rx_bad[0] = 1'b0;
        repeat (2) step();
        read_chk(4'h1, 4'd15, "rd_ch0_sat");
        tx_start[0] = 1'b1;
        repeat (4) step();
        tx_start[0] = 1'b0;
        repeat (2) step();
        rx_bad[0] = 1'b1;
        tx_start[0] = 1'b1;
        step();
        rx_bad[0] = 1'b0;
        tx_start[0] = 1'b0;
        stat_clr_all = 1'b1;
        read_chk(4'h2, 4'd4, "rd_clr_pre");
        stat_clr_all = 1'b0;
        read_chk(4'h2, 4'd0, "rd_clr_tx");
        read_chk(4'h1, 4'd0, "rd_clr_bad");
        read_chk(4'hC, 4'd0, "rd_clr_ch3");

        // 3-channel instance: out-of-range channel reads 0
        rxg3[2] = 1'b1;
        repeat (2) step();
        rxg3[2] = 1'b0;
        repeat (2) step();
        read3_chk(4'h8, 4'd2, "rd3_ch2");
        read3_chk(4'hC, 4'd0, "rd3_oob");

        // reset in the middle of a stretch
        tx_start[2] = 1'b1;
        step();
        tx_start[2] = 1'b0;
        repeat (3) step();
        chk("pre_rst_led_tx", 32'(led_tx), 32'h4);
        chk("pre_rst_led_up", 32'(led_up), 32'h4);
        rst = 1'b1;
        step();
        chk("mid_rst_led_tx", 32'(led_tx), 32'd0);
        chk("mid_rst_led_rx", 32'(led_rx), 32'd0);
        chk("mid_rst_led_up", 32'(led_up), 32'd0);
        chk("mid_rst_link", 32'(link_up), 32'd0);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
